// File: rtl/fpu_ctrl.sv
// FP instruction sequencer: decodes funct7, issues to one unit, waits its latency, retires.
// Optional divider decode enabled by defining FPU_CTRL_FDIV_EN.
module fpu_ctrl #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 6,
  parameter int LAT_SQRT = 5,
  parameter int LAT_CVT  = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [6:0] funct7,
  output logic [2:0] unit_sel,
  output logic       unit_go,
  output logic       flpt_done,
  output logic       fregwrite,
  output logic       iregwrite,
  output logic       illegal,
  output logic       busy
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXL = max2(max2(max2(LAT_ADD, LAT_MUL),
                                  max2(LAT_DIV, LAT_SQRT)),
                             LAT_CVT);
  localparam int CW = (MAXL < 1) ? 1 : $clog2(MAXL + 1);

  localparam logic [2:0] U_ADD  = 3'd0;
  localparam logic [2:0] U_MUL  = 3'd1;
  localparam logic [2:0] U_DIV  = 3'd2;
  localparam logic [2:0] U_SQRT = 3'd3;
  localparam logic [2:0] U_CVT  = 3'd4;
  localparam logic [2:0] U_MISC = 3'd5;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {WB_F, WB_I, WB_ILL} wb_t;

  state_t        state, state_n;
  wb_t           wb_q, dec_wb;
  logic [2:0]    sel_q, dec_sel;
  logic [CW-1:0] cnt, issue_lat;

  always_comb begin
    dec_sel = U_ADD;
    dec_wb  = WB_ILL;
    unique case (1'b1)
      (funct7 == 7'b0000000),
      (funct7 == 7'b0000100): begin
        dec_sel = U_ADD;  dec_wb = WB_F;
      end
      (funct7 == 7'b0001000): begin
        dec_sel = U_MUL;  dec_wb = WB_F;
      end
`ifdef FPU_CTRL_FDIV_EN
      (funct7 == 7'b0001100): begin
        dec_sel = U_DIV;  dec_wb = WB_F;
      end
`endif
      (funct7 == 7'b0101100): begin
        dec_sel = U_SQRT; dec_wb = WB_F;
      end
      (funct7 == 7'b1100000): begin
        dec_sel = U_CVT;  dec_wb = WB_I;
      end
      (funct7 == 7'b1101000): begin
        dec_sel = U_CVT;  dec_wb = WB_F;
      end
      (funct7 == 7'b0010000),
      (funct7 == 7'b0010100),
      (funct7 == 7'b1111000): begin
        dec_sel = U_MISC; dec_wb = WB_F;
      end
      (funct7 == 7'b1010000),
      (funct7 == 7'b1110000): begin
        dec_sel = U_MISC; dec_wb = WB_I;
      end
      default: begin
        dec_sel = U_ADD;  dec_wb = WB_ILL;
      end
    endcase
  end

  // Illegal ops and misc carry zero latency so they skip WAIT.
  always_comb begin
    issue_lat = '0;
    if (wb_q != WB_ILL) begin
      unique case (sel_q)
        U_ADD:   issue_lat = CW'(LAT_ADD);
        U_MUL:   issue_lat = CW'(LAT_MUL);
        U_DIV:   issue_lat = CW'(LAT_DIV);
        U_SQRT:  issue_lat = CW'(LAT_SQRT);
        U_CVT:   issue_lat = CW'(LAT_CVT);
        default: issue_lat = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      sel_q <= U_ADD;
      wb_q  <= WB_F;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        sel_q <= dec_sel;
        wb_q  <= dec_wb;
      end
      if (state == ISSUE)
        cnt <= issue_lat;
      else if (state == WAIT)
        cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    state_n   = state;
    unit_go   = 1'b0;
    flpt_done = 1'b0;
    fregwrite = 1'b0;
    iregwrite = 1'b0;
    illegal   = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: if (start) state_n = ISSUE;
      ISSUE: begin
        unit_go = (wb_q != WB_ILL);
        state_n = (issue_lat != '0) ? WAIT : DONE;
      end
      WAIT: if (cnt == CW'(1)) state_n = DONE;
      DONE: begin
        flpt_done = 1'b1;
        fregwrite = (wb_q == WB_F);
        iregwrite = (wb_q == WB_I);
        illegal   = (wb_q == WB_ILL);
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign unit_sel = sel_q;

endmodule

// File: tb/tb_fpu_ctrl.sv
// Directed bench for fpu_ctrl: decode table plus back-to-back, reset and busy corner cases.
// Expectations follow FPU_CTRL_FDIV_EN when it is defined for the build.
module tb_fpu_ctrl;
  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [6:0] funct7;
  logic [2:0] unit_sel;
  logic       unit_go, flpt_done, fregwrite, iregwrite, illegal, busy;

  int tests = 0;
  int fails = 0;

  fpu_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .funct7(funct7),
    .unit_sel(unit_sel), .unit_go(unit_go), .flpt_done(flpt_done),
    .fregwrite(fregwrite), .iregwrite(iregwrite),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] f7;
    logic [2:0] sel;
    int         done;
    logic       fw;
    logic       iw;
    logic       il;
    int         gos;
  } vec_t;

  vec_t v[14];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issues one op at cycle 0 and follows it to its done pulse.
  task automatic run_op(input logic [6:0] f7, input logic [2:0] esel,
                        output int dc, output int gos,
                        output logic [2:0] s, output logic fw,
                        output logic iw, output logic il,
                        output int bad, output int idle_ok);
    dc = -1; gos = 0; bad = 0; s = '0;
    fw = 1'b0; iw = 1'b0; il = 1'b0; idle_ok = 0;
    @(negedge clk);
    start = 1'b1; funct7 = f7;
    @(posedge clk); #1;
    start = 1'b0; funct7 = 7'h7f;
    for (int c = 1; c <= 20; c++) begin
      if (unit_go) gos++;
      if (!busy || unit_sel != esel) bad++;
      if (flpt_done) begin
        dc = c; s = unit_sel;
        fw = fregwrite; iw = iregwrite; il = illegal;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    idle_ok = (!busy && !flpt_done) ? 1 : 0;
  endtask

  localparam logic [6:0] F_ADD  = 7'b0000000;
  localparam logic [6:0] F_MUL  = 7'b0001000;
  localparam logic [6:0] F_DIV  = 7'b0001100;
  localparam logic [6:0] F_SQRT = 7'b0101100;
`ifdef FPU_CTRL_FDIV_EN
  localparam logic [6:0] F_RST  = F_DIV;
`else
  localparam logic [6:0] F_RST  = F_SQRT;
`endif

  initial begin
    int dc, gos, bad, idle_ok, d1, d2, dn;
    logic [2:0] s;
    logic fw, iw, il;

    v[0]  = '{"fadd",   7'b0000000, 3'd0, 4, 1, 0, 0, 1};
    v[1]  = '{"fsub",   7'b0000100, 3'd0, 4, 1, 0, 0, 1};
    v[2]  = '{"fmul",   7'b0001000, 3'd1, 4, 1, 0, 0, 1};
`ifdef FPU_CTRL_FDIV_EN
    v[3]  = '{"fdiv",   7'b0001100, 3'd2, 8, 1, 0, 0, 1};
`else
    v[3]  = '{"fdiv",   7'b0001100, 3'd0, 2, 0, 0, 1, 0};
`endif
    v[4]  = '{"fsqrt",  7'b0101100, 3'd3, 7, 1, 0, 0, 1};
    v[5]  = '{"cvtws",  7'b1100000, 3'd4, 3, 0, 1, 0, 1};
    v[6]  = '{"cvtsw",  7'b1101000, 3'd4, 3, 1, 0, 0, 1};
    v[7]  = '{"fsgnj",  7'b0010000, 3'd5, 2, 1, 0, 0, 1};
    v[8]  = '{"fminmax",7'b0010100, 3'd5, 2, 1, 0, 0, 1};
    v[9]  = '{"fcmp",   7'b1010000, 3'd5, 2, 0, 1, 0, 1};
    v[10] = '{"fmvxw",  7'b1110000, 3'd5, 2, 0, 1, 0, 1};
    v[11] = '{"fmvwx",  7'b1111000, 3'd5, 2, 1, 0, 0, 1};
    v[12] = '{"ill7f",  7'b1111111, 3'd0, 2, 0, 0, 1, 0};
    v[13] = '{"ill01",  7'b0000001, 3'd0, 2, 0, 0, 1, 0};

    rstn = 1'b0; start = 1'b1; funct7 = F_ADD;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs",
        int'({unit_sel, unit_go, flpt_done, fregwrite,
              iregwrite, illegal, busy}), 0);
    @(negedge clk);
    rstn = 1'b1; start = 1'b0;

    foreach (v[k]) begin
      run_op(v[k].f7, v[k].sel, dc, gos, s, fw, iw, il, bad, idle_ok);
      chk({v[k].name, "_done_cyc"}, dc, v[k].done);
      chk({v[k].name, "_sel"}, int'(s), int'(v[k].sel));
      chk({v[k].name, "_wb"}, int'({fw, iw, il}),
          int'({v[k].fw, v[k].iw, v[k].il}));
      chk({v[k].name, "_go"}, gos, v[k].gos);
      chk({v[k].name, "_stable"}, bad, 0);
      chk({v[k].name, "_idle"}, idle_ok, 1);
    end

    // Back-to-back: start held high across fmul then fsqrt.
    d1 = -1; d2 = -1; gos = 0; dn = 0; s = '0;
    @(negedge clk);
    start = 1'b1; funct7 = F_MUL;
    @(posedge clk); #1;
    funct7 = F_SQRT;
    for (int c = 1; c <= 14; c++) begin
      if (unit_go) gos++;
      if (flpt_done) begin
        dn++;
        if (d1 < 0) d1 = c;
        else begin d2 = c; s = unit_sel; end
      end
      if (c == 6) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_done1", d1, 4);
    chk("b2b_done2", d2, 12);
    chk("b2b_sel2", int'(s), 3);
    chk("b2b_ndone", dn, 2);
    chk("b2b_go", gos, 2);
    chk("b2b_idle", int'(busy), 0);

    // Busy-ignore: new funct7/start during fadd WAIT.
    dc = -1; bad = 0;
    @(negedge clk);
    start = 1'b1; funct7 = F_ADD;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) begin start = 1'b1; funct7 = F_MUL; end
      if (c == 3) start = 1'b0;
      if (busy && unit_sel != 3'd0) bad++;
      if (flpt_done && dc < 0) dc = c;
      @(posedge clk); #1;
    end
    chk("ign_done", dc, 4);
    chk("ign_sel", bad, 0);
    chk("ign_idle", int'(busy), 0);

    // Reset in the middle of WAIT.
    dn = 0;
    @(negedge clk);
    start = 1'b1; funct7 = F_RST;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (flpt_done) dn++;
      if (c < 3) begin @(posedge clk); #1; end
    end
    chk("rstw_busy_c3", int'(busy), 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rstw_outs",
        int'({unit_sel, unit_go, flpt_done, fregwrite,
              iregwrite, illegal, busy}), 0);
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (flpt_done || fregwrite || iregwrite || illegal || busy) dn++;
    end
    chk("rstw_no_done", dn, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
